// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder (SPI mode 0), fully in the core clock domain.
// The sck/csb/sdi pins are oversampled through synchronizers. A command byte,
// an address byte and an auto-incrementing data stream drive a simple
// register-file port. Read data is returned MSB first on sdo.
//
// Register port handshake: reg_re and reg_we are single-cycle strobes
// qualified by reg_addr (and reg_wdata for writes). There is no back-pressure.
// The register file must return reg_rdata in the cycle after reg_re. At most
// one strobe is high in any cycle, and a write at an address always precedes
// the read of the next address.
module hkspi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              sck,
    input  logic              csb,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              reg_we,
    output logic [7:0]        reg_wdata,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_IGNORE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_d;
    logic                   csb_d;
    logic [SYNC_STAGES:0]   pipe_fill;
    logic                   armed;

    logic sck_s;
    logic csb_s;
    logic sdi_s;
    logic sck_rise;
    logic sck_fall;
    logic csb_rise;
    logic csb_fall;

    // Transaction state
    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  tx_shift;
    logic        wr_en;
    logic        rd_en;
    logic        inc_pend;
    logic        load_pend;
    logic        byte_done;
    logic [7:0]  byte_in;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign csb_rise  = csb_s & ~csb_d;
    assign csb_fall  = ~csb_s & csb_d;
    assign byte_in   = {shift_in, sdi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Pin synchronizers, one-cycle delayed copies for edge detection, and arming.
    // The csb chain resets high, so a pin held low through reset looks like a fall.
    // armed is set only once csb has been seen high after the chain has filled
    // with real pin samples. This stops that false fall from opening a transaction.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync  <= '0;
            csb_sync  <= '1;
            sdi_sync  <= '0;
            sck_d     <= 1'b0;
            csb_d     <= 1'b1;
            pipe_fill <= '0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sck_d     <= sck_s;
            csb_d     <= csb_s;
            pipe_fill <= {pipe_fill[SYNC_STAGES-1:0], 1'b1};
            if (pipe_fill[SYNC_STAGES] && csb_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Protocol FSM with byte framing, register strobes and the sdo shifter.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            tx_shift  <= 8'd0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            inc_pend  <= 1'b0;
            load_pend <= 1'b0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_re    <= 1'b0;
            reg_we    <= 1'b0;
            reg_wdata <= 8'd0;
        end else begin
            reg_re <= 1'b0;
            reg_we <= 1'b0;
            if (state != S_IDLE && csb_rise) begin
                // Close the transaction. Any partial byte is simply dropped.
                state     <= S_IDLE;
                bit_cnt   <= 3'd0;
                wr_en     <= 1'b0;
                rd_en     <= 1'b0;
                inc_pend  <= 1'b0;
                load_pend <= 1'b0;
                sdo       <= 1'b0;
                sdo_oe    <= 1'b0;
            end else begin
                // Read data arrives one cycle after reg_re and reloads the shifter.
                load_pend <= reg_re;
                if (load_pend) begin
                    tx_shift <= reg_rdata;
                end else if (sck_fall && state == S_DATA && rd_en) begin
                    sdo      <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end

                // The address step after a write, followed by the read of the new address.
                if (inc_pend) begin
                    inc_pend <= 1'b0;
                    reg_addr <= reg_addr + ADDR_ONE;
                    reg_re   <= rd_en;
                end

                if (sck_rise && state != S_IDLE) begin
                    shift_in <= byte_in[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end

                case (state)
                    S_IDLE: begin
                        bit_cnt <= 3'd0;
                        if (armed && csb_fall) begin
                            state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (byte_done) begin
                            case (byte_in)
                                8'h80: begin
                                    wr_en <= 1'b1;
                                    rd_en <= 1'b0;
                                    state <= S_ADDR;
                                end
                                8'h40: begin
                                    wr_en <= 1'b0;
                                    rd_en <= 1'b1;
                                    state <= S_ADDR;
                                end
                                8'hC0: begin
                                    wr_en <= 1'b1;
                                    rd_en <= 1'b1;
                                    state <= S_ADDR;
                                end
                                default: begin
                                    state <= S_IGNORE;
                                end
                            endcase
                        end
                    end
                    S_ADDR: begin
                        if (byte_done) begin
                            reg_addr <= ADDR_W'(byte_in);
                            reg_re   <= rd_en;
                            sdo_oe   <= rd_en;
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (byte_done) begin
                            if (wr_en) begin
                                reg_we    <= 1'b1;
                                reg_wdata <= byte_in;
                                inc_pend  <= 1'b1;
                            end else begin
                                reg_addr <= reg_addr + ADDR_ONE;
                                reg_re   <= rd_en;
                            end
                        end
                    end
                    S_IGNORE: begin
                        state <= S_IGNORE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hkspi_responder.sv
// Testbench for hkspi_responder: drives SPI mode 0 transactions against a
// small register bank and checks strobes, addresses and returned read data.
module tb_hkspi_responder;

    localparam int H = 6;   // sck half period in core clocks

    logic       clock;
    logic       resetb;
    logic       sck;
    logic       csb;
    logic       sdi;
    logic       sdo;
    logic       sdo_oe;
    logic [7:0] reg_addr;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic       busy;
    logic [2:0] dbg_state;

    hkspi_responder #(.SYNC_STAGES(2), .ADDR_W(8)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .sck       (sck),
        .csb       (csb),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .reg_addr  (reg_addr),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- register bank ----------------
    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h00: return 8'h00;  8'h01: return 8'h04;  8'h02: return 8'h56;
            8'h03: return 8'h11;  8'h04: return 8'h01;  8'h05: return 8'ha5;
            8'h06: return 8'h5a;  8'h07: return 8'hc3;  8'h08: return 8'h3c;
            8'h09: return 8'h02;  8'h0a: return 8'hff;  8'h0b: return 8'h0b;
            8'h0c: return 8'h12;  8'h0d: return 8'h80;  8'h0e: return 8'h7f;
            8'h0f: return 8'he1;  8'h10: return 8'h1e;  8'h11: return 8'h99;
            8'h12: return 8'h04;  8'hff: return 8'h9f;
            default: return a ^ 8'h5a;
        endcase
    endfunction

    logic [7:0] bank [256];
    logic [7:0] ref_mem [256];
    logic       load_bank;

    always @(posedge clock) begin
        if (load_bank) begin
            for (int i = 0; i < 256; i++) bank[i] <= init_val(8'(i));
        end else begin
            if (reg_re) reg_rdata <= bank[reg_addr];
            if (reg_we) bank[reg_addr] <= reg_wdata;
        end
    end

    // ---------------- monitor (records events only) ----------------
    logic [15:0] we_log[$];
    logic [7:0]  re_log[$];
    int          both_cnt = 0;
    int          oe_count = 0;

    always @(negedge clock) begin
        if (reg_we) we_log.push_back({reg_addr, reg_wdata});
        if (reg_re) re_log.push_back(reg_addr);
        if (reg_we && reg_re) both_cnt++;
        if (sdo_oe) oe_count++;
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_re_q[$];
    int          we_rd = 0;
    int          re_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drain_scoreboard(input string tag);
        chk({tag, " we_count"}, we_log.size() - we_rd, exp_q.size());
        while (exp_q.size() > 0 && we_rd < we_log.size()) begin
            chk({tag, " we"}, we_log[we_rd], exp_q.pop_front());
            we_rd++;
        end
        we_rd = we_log.size();
        exp_q.delete();
        chk({tag, " re_count"}, re_log.size() - re_rd, exp_re_q.size());
        while (exp_re_q.size() > 0 && re_rd < re_log.size()) begin
            chk({tag, " re_addr"}, re_log[re_rd], exp_re_q.pop_front());
            re_rd++;
        end
        re_rd = re_log.size();
        exp_re_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Shift nb bits MSB first. sdo is sampled just before each rising sck.
    task automatic spi_bits(input logic [7:0] v, input int nb, input logic exp_oe,
                            output logic [7:0] rx, output int oe_bad);
        rx = 8'h00;
        oe_bad = 0;
        for (int i = 0; i < nb; i++) begin
            sdi = v[7-i];
            wait_clk(H);
            rx = {rx[6:0], sdo};
            if (sdo_oe !== exp_oe) oe_bad++;
            sck = 1'b1;
            wait_clk(H);
            sck = 1'b0;
        end
    endtask

    task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                           input int n, input logic [31:0] wds,
                           input logic [7:0] exp_first, input logic [7:0] end_addr);
        logic       valid, wr, rd;
        logic [7:0] rx, a, w;
        int         ob, oe_bad_tot, oe0;
        valid = (cmd == 8'h80) || (cmd == 8'h40) || (cmd == 8'hC0);
        wr = valid && cmd[7];
        rd = valid && cmd[6];
        oe0 = oe_count;
        oe_bad_tot = 0;
        csb = 1'b0;
        wait_clk(H);
        spi_bits(cmd, 8, 1'b0, rx, ob);
        oe_bad_tot += ob;
        chk({tag, " busy"}, busy, 1'b1);
        if (!valid) chk({tag, " ignore_state"}, dbg_state, 3'd4);
        spi_bits(addr, 8, 1'b0, rx, ob);
        oe_bad_tot += ob;
        if (rd) exp_re_q.push_back(addr);
        for (int k = 0; k < n; k++) begin
            a = addr + 8'(k);
            w = (k < 4) ? wds[31-8*k -: 8] : 8'h00;
            spi_bits(w, 8, rd, rx, ob);
            oe_bad_tot += ob;
            if (rd) begin
                if (k == 0) chk({tag, " first_rd"}, rx, exp_first);
                chk({tag, " rd"}, rx, ref_mem[a]);
                exp_re_q.push_back(a + 8'd1);
            end
            if (wr) begin
                exp_q.push_back({a, w});
                ref_mem[a] = w;
            end
        end
        wait_clk(H);
        csb = 1'b1;
        wait_clk(2 * H);
        chk({tag, " sdo_oe_window"}, oe_bad_tot, 0);
        chk({tag, " idle"}, {busy, sdo_oe, sdo}, 3'b000);
        chk({tag, " end_addr"}, reg_addr, end_addr);
        if (!rd) chk({tag, " oe_quiet"}, oe_count - oe0, 0);
        drain_scoreboard(tag);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          n;
        logic [31:0] wds;
        logic [7:0]  exp_first;
        logic [7:0]  end_addr;
    } txn_t;

    txn_t tbl[9];

    initial begin
        logic [7:0] rx;
        int         ob, we0, re0, oe0;

        tbl[0] = '{8'h40, 8'h03, 1,  32'h0000_0000, 8'h11, 8'h04};  // read reg 3
        tbl[1] = '{8'h80, 8'h0b, 1,  32'h0100_0000, 8'h00, 8'h0c};  // write 0x01
        tbl[2] = '{8'h80, 8'h0b, 1,  32'h0000_0000, 8'h00, 8'h0c};  // write 0x00
        tbl[3] = '{8'h40, 8'h00, 19, 32'h0000_0000, 8'h00, 8'h13};  // 19-byte read
        tbl[4] = '{8'hC0, 8'hff, 2,  32'hAA55_0000, 8'h9f, 8'h01};  // RW across wrap
        tbl[5] = '{8'h40, 8'h0b, 1,  32'h0000_0000, 8'h00, 8'h0c};  // readback write
        tbl[6] = '{8'h00, 8'h00, 2,  32'h1234_0000, 8'h00, 8'h0c};  // invalid cmd
        tbl[7] = '{8'h40, 8'hff, 2,  32'h0000_0000, 8'hAA, 8'h01};  // read across wrap
        tbl[8] = '{8'hC0, 8'h10, 3,  32'hC3A5_0F00, 8'h1e, 8'h13};  // RW stream

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

        // ---------------- reset ----------------
        resetb = 1'b0;
        sck = 1'b0;
        csb = 1'b1;
        sdi = 1'b0;
        load_bank = 1'b1;
        wait_clk(4);
        load_bank = 1'b0;
        chk("reset outputs", {sdo, sdo_oe, reg_re, reg_we, busy}, 5'b0);
        chk("reset addr_wdata", {reg_addr, reg_wdata}, 16'h0000);
        chk("reset state", dbg_state, 3'd0);
        resetb = 1'b1;
        wait_clk(10);

        // ---------------- table-driven transactions ----------------
        for (int t = 0; t < 9; t++) begin
            run_txn($sformatf("txn%0d", t), tbl[t].cmd, tbl[t].addr, tbl[t].n,
                    tbl[t].wds, tbl[t].exp_first, tbl[t].end_addr);
        end
        chk("strobe_overlap", both_cnt, 0);

        // ---------------- abort: csb rises after 5 data bits of a write ----------------
        we0 = we_log.size();
        re0 = re_log.size();
        csb = 1'b0;
        wait_clk(H);
        spi_bits(8'h80, 8, 1'b0, rx, ob);
        spi_bits(8'h20, 8, 1'b0, rx, ob);
        spi_bits(8'hF0, 5, 1'b0, rx, ob);
        wait_clk(H);
        csb = 1'b1;
        wait_clk(2 * H);
        chk("abort we", we_log.size() - we0, 0);
        chk("abort re", re_log.size() - re0, 0);
        chk("abort addr", reg_addr, 8'h20);
        chk("abort idle", busy, 1'b0);

        // ---------------- reset mid-transfer, csb held low afterwards ----------------
        csb = 1'b0;
        wait_clk(H);
        spi_bits(8'h40, 8, 1'b0, rx, ob);
        spi_bits(8'h05, 4, 1'b0, rx, ob);
        chk("pre_reset busy", busy, 1'b1);
        resetb = 1'b0;
        #1;
        chk("midrst outputs", {sdo, sdo_oe, reg_re, reg_we, busy}, 5'b0);
        chk("midrst addr_wdata", {reg_addr, reg_wdata}, 16'h0000);
        wait_clk(3);
        resetb = 1'b1;
        we0 = we_log.size();
        re0 = re_log.size();
        oe0 = oe_count;
        spi_bits(8'h40, 8, 1'b0, rx, ob);
        spi_bits(8'h03, 8, 1'b0, rx, ob);
        spi_bits(8'h00, 8, 1'b0, rx, ob);
        chk("held_low busy", busy, 1'b0);
        chk("held_low strobes", (we_log.size() - we0) + (re_log.size() - re0), 0);
        chk("held_low oe", oe_count - oe0, 0);
        csb = 1'b1;
        wait_clk(2 * H);
        run_txn("post_reset", 8'h40, 8'h12, 2, 32'h0, 8'h0f, 8'h14);
        chk("final strobe_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hkspi_responder.md
Name: hkspi_responder

Overview:
SPI responder for the housekeeping SPI. It receives the external master's serial stream on pins sck/csb/sdi and returns read data on sdo. It decodes a command byte, an address byte and a data stream with auto-increment, and drives a simple register-file port owned by the housekeeping block. All logic runs in the core clock domain and oversamples the SPI pins; it sits between the mprj_io[4:1] pad nets and the housekeeping register bank.

Parameters:
SYNC_STAGES, 2, number of flops in each of the sck/csb/sdi input synchronizers (minimum 2)
ADDR_W, 8, register address width (data width fixed at 8)

Ports:
clock  input  1  core clock
resetb  input  1  asynchronous active-low reset
sck  input  1  SPI clock from pad, asynchronous
csb  input  1  SPI chip select, active low, asynchronous
sdi  input  1  SPI serial data in, MSB first
sdo  output  1  SPI serial data out, MSB first
sdo_oe  output  1  pad output enable for sdo
reg_addr  output  ADDR_W  register address
reg_re  output  1  one-cycle read strobe
reg_rdata  input  8  register read data, valid in the cycle after reg_re
reg_we  output  1  one-cycle write strobe
reg_wdata  output  8  register write data
busy  output  1  high while a transaction is open (state != IDLE)

Behaviour:
- Reset values: sdo=0, sdo_oe=0, reg_addr=0, reg_re=0, reg_we=0, reg_wdata=0, busy=0, state=IDLE.
- Synchronization and edge detection:
  - sck, csb and sdi each pass through SYNC_STAGES flops; the csb synchronizer resets to 1.
  - Rise and fall of synchronized sck are detected by comparing against a one-cycle-delayed copy.
  - Pin-to-event latency is SYNC_STAGES+1 clocks.
- SPI mode 0:
  - sdi is sampled on the detected sck rise.
  - sdo changes on the detected sck fall.
  - Legal SCK high and low times are each ≥ SYNC_STAGES+3 clocks.
- Byte framing: a 3-bit bit counter and 8-bit shift-in register. A byte completes on the 8th sck rise; the counter wraps to 0.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE→CMD on synchronized csb fall; the counter clears.
  - CMD→ADDR on byte complete when the command is 0x80 (write stream), 0x40 (read stream) or 0xC0 (read/write stream); the wr_en/rd_en flags latch. Any other command goes to IGNORE.
  - ADDR→DATA on byte complete: reg_addr←byte. If rd_en, reg_re pulses in the next cycle, and one cycle later tx_shift←reg_rdata.
  - DATA, each completed byte:
    - if wr_en: reg_we pulses one cycle with reg_wdata=byte at the current reg_addr;
    - then reg_addr increments modulo 2^ADDR_W (0xFF→0x00);
    - then, if rd_en: reg_re pulses at the new address and tx_shift reloads.
  - IGNORE holds until csb rises. No strobes are issued and sdo_oe stays 0.
  - Any state→IDLE on synchronized csb rise. A partial byte is discarded with no reg_we, and sdo_oe drops in the same cycle.
- SDO:
  - sdo_oe=1 only in DATA with rd_en.
  - On the first sck fall in DATA, and on each fall after a reload, sdo←tx_shift[7]; subsequent falls shift left.
  - The falling edge that ends the address byte presents bit 7 of the first read byte. The reg_re/reload path must complete within the sck low time.
  - When sdo_oe=0, sdo=0.
- Read/write stream (0xC0): the read of address A is issued before the write of A, so sdo returns the old value.
- Reset asserted mid-transfer forces the reset values immediately. After release the block waits in IDLE for a fresh csb fall; a held-low csb does not restart a transaction.
- At most one of reg_re/reg_we is high in any cycle; reg_we precedes reg_re when both are due.

Test Plan:
- Read stream: csb low, send 0x40, 0x03, clock 8 bits, with register 3=0x11 → reg_re at addr 0x03, sdo shifts 0x11 MSB first, sdo_oe=1 only during the data byte.
- Write stream: send 0x80, 0x0b, 0x01 then 0x80, 0x0b, 0x00 → exactly two reg_we pulses, addr 0x0b, data 0x01 then 0x00; sdo_oe stays 0.
- Auto-increment: send 0x40, 0x00, read 19 bytes from a model bank (0x00,0x04,0x56,0x11,…,0x04) → reg_addr steps 0x00..0x12, all 19 bytes match.
- Wrap and RW: send 0xC0, 0xFF, write 0xAA, 0x55 → writes at 0xFF then 0x00, sdo returns the old contents of 0xFF and 0x00, reg_addr ends at 0x01.
- Abort/invalid: csb rises after 5 data bits of a write → no reg_we. Command 0x00 → no strobes and sdo_oe=0 until csb rises, after which the next 0x40 transaction works.
- Reset mid-transfer: resetb low during the address byte → all outputs return to reset values. With csb held low after release → no activity. A new csb cycle with a read → correct data.
